// File: rtl/lfsr_checker_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_checker_pkg
//   Shared definitions for the 32-bit XNOR LFSR pattern generator and checker:
//   register width, tap positions (31,21,1,0), fill-counter sizing, counter
//   width, the checker state enum and the next-bit prediction function.
// -----------------------------------------------------------------------------
package lfsr_checker_pkg;

  localparam int LFSR_W = 32;

  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  // Fill counter runs 0..32, so it needs 6 bits.
  localparam int                 FILL_W    = 6;
  localparam logic [FILL_W-1:0]  FILL_DONE = 6'd32;

  localparam int CNT_W = 32;

  typedef enum logic {
    FILL  = 1'b0,
    CHECK = 1'b1
  } lfsr_state_e;

  // XNOR feedback: the all-ones register maps onto itself (lockup state).
  function automatic logic lfsr_predict(input logic [LFSR_W-1:0] h);
    return ~(h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D]);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
//   Bundles the serial input, the counter clear and the status/counter outputs
//   of the LFSR checker.
//     in_bit, in_valid : received bit and its qualifier
//     clear            : synchronous clear of err_count / bit_count
//     locked           : checker is in CHECK
//     err_pulse        : one-cycle flag per mismatched bit
//     err_count        : saturating mismatch total
//     bit_count        : saturating total of checked bits
//   master = bit source / monitor, slave = the checker.
// -----------------------------------------------------------------------------
interface lfsr_checker_if;
  import lfsr_checker_pkg::*;

  logic             in_bit;
  logic             in_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output in_bit, in_valid, clear,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  in_bit, in_valid, clear,
    output locked, err_pulse, err_count, bit_count
  );

endinterface

// File: rtl/lfsr_sat_counter.sv
// -----------------------------------------------------------------------------
// lfsr_sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   : clock
//     rst_n : synchronous active-low reset, zeroes the count
//     clear : synchronous clear, takes priority over inc
//     inc   : add one unless already at all-ones
//     count : current value (registered)
// -----------------------------------------------------------------------------
module lfsr_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side checker for a 32-bit XNOR LFSR stream (taps 31,21,1,0).
//   FILL : loads 32 received bits into the history register; locks once 32
//          bits are in and the history is not the all-ones lockup pattern.
//   CHECK: runs the history as a free-running reference (the prediction, not
//          the received bit, is shifted in) so a corrupted bit is counted once
//          and never poisons later predictions. Errors are accumulated per
//          WINDOW checked bits; LOSS_THRESH errors in one window drops lock.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : lfsr_checker_if.slave (in_bit, in_valid, clear, locked,
//             err_pulse, err_count, bit_count)
//   All outputs are registered: one cycle after the valid bit is accepted.
// -----------------------------------------------------------------------------
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_checker_if.slave bus
);

  localparam int WBIT_W = $clog2(WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [WBIT_W-1:0] WBIT_END  = WBIT_W'(WINDOW);
  localparam logic [WERR_W-1:0] WERR_LOSS = WERR_W'(LOSS_THRESH);

  lfsr_state_e        state_p1, state_nxt;
  logic [LFSR_W-1:0]  hist_p1, hist_nxt;
  logic [FILL_W-1:0]  fill_p1, fill_nxt;
  logic [WBIT_W-1:0]  wbit_p1, wbit_nxt, wbit_sum;
  logic [WERR_W-1:0]  werr_p1, werr_nxt, werr_sum;
  logic               err_pulse_p1, err_pulse_nxt;
  logic               pred_p0, mismatch_p0;
  logic               bit_inc, err_inc;

  // ---- stage p0: prediction and compare against the received bit ----
  assign pred_p0     = lfsr_predict(hist_p1);
  assign mismatch_p0 = bus.in_bit ^ pred_p0;
  assign wbit_sum    = wbit_p1 + WBIT_W'(1);
  assign werr_sum    = werr_p1 + WERR_W'(mismatch_p0);

  always_comb begin
    state_nxt     = state_p1;
    hist_nxt      = hist_p1;
    fill_nxt      = fill_p1;
    wbit_nxt      = wbit_p1;
    werr_nxt      = werr_p1;
    err_pulse_nxt = 1'b0;
    bit_inc       = 1'b0;
    err_inc       = 1'b0;

    if (bus.in_valid) begin
      unique case (state_p1)
        FILL: begin
          hist_nxt = {hist_p1[LFSR_W-2:0], bus.in_bit};
          // Counter stops at 32 so an all-ones lockup retries on every bit.
          if (fill_p1 != FILL_DONE) begin
            fill_nxt = fill_p1 + FILL_W'(1);
          end
          if ((fill_nxt == FILL_DONE) && (hist_nxt != {LFSR_W{1'b1}})) begin
            state_nxt = CHECK;
          end
        end

        CHECK: begin
          hist_nxt      = {hist_p1[LFSR_W-2:0], pred_p0};
          bit_inc       = 1'b1;
          err_inc       = mismatch_p0;
          err_pulse_nxt = mismatch_p0;
          // Loss of lock outranks the window rollover on the same bit.
          if (werr_sum >= WERR_LOSS) begin
            state_nxt = FILL;
            fill_nxt  = '0;
            wbit_nxt  = '0;
            werr_nxt  = '0;
          end else if (wbit_sum == WBIT_END) begin
            wbit_nxt  = '0;
            werr_nxt  = '0;
          end else begin
            wbit_nxt  = wbit_sum;
            werr_nxt  = werr_sum;
          end
        end

        default: begin
          state_nxt = FILL;
        end
      endcase
    end
  end

  // ---- stage p1: state, history, window counters and error flag ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1     <= FILL;
      hist_p1      <= '0;
      fill_p1      <= '0;
      wbit_p1      <= '0;
      werr_p1      <= '0;
      err_pulse_p1 <= 1'b0;
    end else begin
      state_p1     <= state_nxt;
      hist_p1      <= hist_nxt;
      fill_p1      <= fill_nxt;
      wbit_p1      <= wbit_nxt;
      werr_p1      <= werr_nxt;
      err_pulse_p1 <= err_pulse_nxt;
    end
  end

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.clear),
    .inc   (err_inc),
    .count (bus.err_count)
  );

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.clear),
    .inc   (bit_inc),
    .count (bus.bit_count)
  );

  assign bus.locked    = (state_p1 == CHECK);
  assign bus.err_pulse = err_pulse_p1;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//   Drives an XNOR LFSR stream (taps 31,21,1,0, seed 0) into lfsr_checker and
//   scores locked / err_pulse per accepted bit through an expectation queue,
//   plus the counters at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lfsr_checker_if bus ();

  lfsr_checker #(
    .WINDOW      (64),
    .LOSS_THRESH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic lock;
    logic pulse;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] gen;
  int          errors = 0;
  int          checks = 0;

  task automatic gen_bit(output logic b);
    b   = ~(gen[31] ^ gen[21] ^ gen[1] ^ gen[0]);
    gen = {gen[30:0], b};
  endtask

  task automatic cycle(input logic b, input logic v, input logic clr);
    bus.in_bit   = b;
    bus.in_valid = v;
    bus.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    gen   = 32'h0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset.locked got=%b exp=0", bus.locked); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset.err_pulse got=%b exp=0", bus.err_pulse); end
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL reset.err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL reset.bit_count got=%0d exp=0", bus.bit_count); end
  endtask

  task automatic test_clean();
    logic b; exp_t e;
    do_reset();
    for (int k = 1; k <= 1000; k++) begin
      gen_bit(b);
      e.lock = (k >= 32); e.pulse = 1'b0;
      sb.push_back(e);
      cycle(b, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL clean.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL clean.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL clean.err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd968) begin errors++; $display("FAIL clean.bit_count got=%0d exp=968", bus.bit_count); end
  endtask

  task automatic test_single_error();
    logic b, inv; exp_t e; int pulses;
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 1000; k++) begin
      gen_bit(b);
      inv = (k == 100);
      e.lock = (k >= 32); e.pulse = inv;
      sb.push_back(e);
      cycle(b ^ inv, 1'b1, 1'b0);
      e = sb.pop_front();
      if (bus.err_pulse === 1'b1) pulses++;
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL single.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL single.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single.pulses got=%0d exp=1", pulses); end
    checks++; if (bus.err_count !== 32'd1) begin errors++; $display("FAIL single.err_count got=%0d exp=1", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd968) begin errors++; $display("FAIL single.bit_count got=%0d exp=968", bus.bit_count); end
  endtask

  // Eight errors at bits 40..47 (first window after lock at bit 32): lock
  // drops after bit 47 and returns 32 valid bits later, after bit 79.
  task automatic test_loss();
    logic b, inv; exp_t e;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      gen_bit(b);
      inv = (k >= 40 && k <= 47);
      e.lock = (k >= 32) && ((k < 47) || (k >= 79)); e.pulse = inv;
      sb.push_back(e);
      cycle(b ^ inv, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL loss.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL loss.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (bus.err_count !== 32'd8) begin errors++; $display("FAIL loss.err_count got=%0d exp=8", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd86) begin errors++; $display("FAIL loss.bit_count got=%0d exp=86", bus.bit_count); end
  endtask

  // Window 1 covers bits 33..96. Seven errors at its tail plus seven at the
  // head of window 2 must not drop lock.
  task automatic test_window_boundary();
    logic b, inv; exp_t e;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      gen_bit(b);
      inv = (k >= 90 && k <= 103);
      e.lock = (k >= 32); e.pulse = inv;
      sb.push_back(e);
      cycle(b ^ inv, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL window.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL window.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (bus.err_count !== 32'd14) begin errors++; $display("FAIL window.err_count got=%0d exp=14", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd168) begin errors++; $display("FAIL window.bit_count got=%0d exp=168", bus.bit_count); end
  endtask

  // Eighth error lands on bit 96, the last bit of window 1: lock must drop.
  task automatic test_coincide();
    logic b, inv; exp_t e;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      gen_bit(b);
      inv = (k >= 89 && k <= 96);
      e.lock = (k >= 32) && ((k < 96) || (k >= 128)); e.pulse = inv;
      sb.push_back(e);
      cycle(b ^ inv, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL coincide.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL coincide.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (bus.err_count !== 32'd8) begin errors++; $display("FAIL coincide.err_count got=%0d exp=8", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd136) begin errors++; $display("FAIL coincide.bit_count got=%0d exp=136", bus.bit_count); end
  endtask

  // 40 ones leave the history all-ones; a single 0 afterwards locks at once.
  task automatic test_lockup();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 41; k++) begin
      e.lock = (k == 41); e.pulse = 1'b0;
      sb.push_back(e);
      cycle((k == 41) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL lockup.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== e.pulse) begin errors++; $display("FAIL lockup.err_pulse k=%0d got=%b exp=%b", k, bus.err_pulse, e.pulse); end
    end
    checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL lockup.bit_count got=%0d exp=0", bus.bit_count); end
  endtask

  task automatic test_valid_toggle();
    logic b; exp_t e;
    do_reset();
    for (int k = 1; k <= 1000; k++) begin
      gen_bit(b);
      e.lock = (k >= 32); e.pulse = 1'b0;
      sb.push_back(e);
      cycle(b, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL toggle.locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      cycle(~b, 1'b0, 1'b0);
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL toggle.idle_locked k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
      checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL toggle.err_pulse k=%0d got=%b exp=0", k, bus.err_pulse); end
    end
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL toggle.err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd968) begin errors++; $display("FAIL toggle.bit_count got=%0d exp=968", bus.bit_count); end
  endtask

  task automatic test_reset_mid_check();
    logic b, inv; exp_t e;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      gen_bit(b);
      inv = (k == 45);
      cycle(b ^ inv, 1'b1, 1'b0);
    end
    checks++; if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) begin errors++; $display("FAIL midrst.pre got=%b%b exp=10", bus.locked, bus.err_pulse); end
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst.locked got=%b exp=0", bus.locked); end
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL midrst.err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL midrst.bit_count got=%0d exp=0", bus.bit_count); end
    for (int k = 1; k <= 40; k++) begin
      gen_bit(b);
      e.lock = (k >= 32); e.pulse = 1'b0;
      sb.push_back(e);
      cycle(b, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.locked !== e.lock) begin errors++; $display("FAIL midrst.relock k=%0d got=%b exp=%b", k, bus.locked, e.lock); end
    end
    checks++; if (bus.bit_count !== 32'd8) begin errors++; $display("FAIL midrst.final_bits got=%0d exp=8", bus.bit_count); end
  endtask

  task automatic test_clear();
    logic b, inv;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      gen_bit(b);
      inv = (k == 35);
      cycle(b ^ inv, 1'b1, 1'b0);
    end
    checks++; if (bus.err_count !== 32'd1) begin errors++; $display("FAIL clear.pre_err got=%0d exp=1", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd8) begin errors++; $display("FAIL clear.pre_bits got=%0d exp=8", bus.bit_count); end
    gen_bit(b);
    cycle(~b, 1'b1, 1'b1);
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL clear.err_count got=%0d exp=0", bus.err_count); end
    checks++; if (bus.bit_count !== 32'd0) begin errors++; $display("FAIL clear.bit_count got=%0d exp=0", bus.bit_count); end
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL clear.err_pulse got=%b exp=1", bus.err_pulse); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clear.locked got=%b exp=1", bus.locked); end
    gen_bit(b);
    cycle(b, 1'b1, 1'b0);
    checks++; if (bus.bit_count !== 32'd1) begin errors++; $display("FAIL clear.after_bits got=%0d exp=1", bus.bit_count); end
    checks++; if (bus.err_count !== 32'd0) begin errors++; $display("FAIL clear.after_err got=%0d exp=0", bus.err_count); end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    gen          = 32'h0;
    #2;
    test_reset();
    test_clean();
    test_single_error();
    test_loss();
    test_window_boundary();
    test_coincide();
    test_lockup();
    test_valid_toggle();
    test_reset_mid_check();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter WINDOW, default 64, is the number of valid bits per error-density window in CHECK.
REQ-002 Parameter LOSS_THRESH, default 8, is the number of errors within one window that drops lock.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_bit  input  1  received serial bit from the 32-bit XNOR LFSR generator (taps 31,21,1,0).
REQ-006 in_valid  input  1  qualifies in_bit; with in_valid low, no state changes.
REQ-007 clear  input  1  synchronous clear of err_count and bit_count only.
REQ-008 locked  output  1  high while in CHECK.
REQ-009 err_pulse  output  1  registered, one-cycle high per mismatched bit in CHECK.
REQ-010 err_count  output  32  total mismatches since reset/clear; saturates at 0xFFFFFFFF.
REQ-011 bit_count  output  32  total valid bits checked in CHECK; saturates at 0xFFFFFFFF.

Function
REQ-012 History register h[31:0] holds the last 32 accepted bits, h[0] newest; each accepted bit shifts in as h <= {h[30:0], x}.
REQ-013 Predicted bit p = h[31] ^ h[21] ^ h[1] ^ h[0] ^ 1.
REQ-014 States: FILL, CHECK; reset state FILL.
REQ-015 FILL: each valid bit shifts in in_bit and increments fill counter (6-bit, 0..32); no comparison, no counting.
REQ-016 FILL -> CHECK when the fill counter reaches 32 and h is not all-ones; otherwise stay in FILL.
REQ-017 If h is all-ones after 32 fills (XNOR lockup), the fill counter holds at 32 and lock is attempted again on each subsequent valid bit.
REQ-018 CHECK: each valid bit shifts p, not in_bit, into h (free-running reference), so every corrupted bit counts once.
REQ-019 CHECK: in_bit != p -> err_pulse high next cycle, err_count +1, window error count +1.
REQ-020 CHECK: every valid bit -> bit_count +1 and window bit count +1.
REQ-021 At window bit count == WINDOW, both window counters return to 0 on that bit.
REQ-022 Window error count reaching LOSS_THRESH -> next state FILL with fill counter 0 and window counters 0; err_count and bit_count are retained.
REQ-023 When threshold and window end coincide on the same bit, loss of lock takes priority.
REQ-024 All outputs are registered, with one-cycle latency from the valid bit.
REQ-025 When clear and a counted bit coincide, clear wins and both counters read 0.
REQ-026 Saturated counters hold their value until clear or reset.

Reset
REQ-027 rst_n low at a clock edge sets state FILL, h = 0, and fill/window counters = 0.
REQ-028 rst_n low at a clock edge sets locked = 0, err_pulse = 0, err_count = 0 and bit_count = 0.
REQ-029 Reset asserted mid-CHECK aborts immediately; relock requires 32 new valid bits.

Structure
REQ-030 A shared package holds the tap positions (31,21,1,0), width 32, and the state enum FILL/CHECK, for use by both the generator and lfsr_checker.
REQ-031 One sub-module, lfsr_sat_counter, implements the saturating 32-bit counter with clear, instantiated twice.

Verification
REQ-032 Generator seeded 0x00000000 drives 1000 valid bits -> locked high after bit 32, err_count = 0, bit_count = 968.
REQ-033 Same stream with bit 100 inverted -> exactly one err_pulse, err_count = 1, locked stays high.
REQ-034 After lock, 8 inverted bits within one 64-bit window -> locked falls, then re-asserts 32 valid bits later, err_count = 8.
REQ-035 Constant 1s for 40 valid bits -> locked stays 0 (all-ones lockup).
REQ-036 in_valid toggling 50% on a clean stream -> same lock point and counts as the continuous case.
REQ-037 rst_n low for one cycle mid-CHECK -> all outputs 0 next cycle, relock after 32 valid bits.
